temporal_encoder: RTL and testbench

//  Temporal N-gram stage directly downstream of the spatial encoder.
//  - Consumes one spatial hypervector per handshake and keeps the last NGRAM_SIZE-1 of them.
//  - Emits the N-gram hypervector x_t ^ rho(x_t-1) ^ ... ^ rho^(N-1)(x_t-N+1); rho = rotate by 1.
//  - Output feeds the associative-memory / training stage.

---
 rtl/temporal_encoder_pkg.sv | 20 ++
 rtl/temporal_encoder_hv_permute.sv | 13 +
 rtl/temporal_encoder.sv | 122 ++++++++++++
 tb/tb_temporal_encoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/temporal_encoder_pkg.sv
// Shared constants, FSM state encoding and width helper for the temporal N-gram encoder.
package temporal_encoder_pkg;

    localparam int DEF_HV_DIMENSION = 2000;
    localparam int DEF_NGRAM_SIZE   = 3;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Never returns 0 so that a counter of this width is always legal, even for N=1.
    function automatic int ceil_log2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/temporal_encoder_hv_permute.sv
// Combinational rho(): rotate a hypervector by one position, o[i] = i[(i-1) mod D].
module temporal_encoder_hv_permute
    import temporal_encoder_pkg::*;
#(
    parameter int HV_DIMENSION = DEF_HV_DIMENSION
) (
    input  logic [HV_DIMENSION-1:0] i_hv,
    output logic [HV_DIMENSION-1:0] o_hv
);

    assign o_hv = {i_hv[HV_DIMENSION-2:0], i_hv[HV_DIMENSION-1]};

endmodule

// File: rtl/temporal_encoder.sv
// Temporal N-gram encoder: out = x ^ rho(x-1) ^ ... ^ rho^(N-1)(x-N+1), with a
// ready/valid handshake on both sides and a registered output.
//
//   state | meaning
//   FILL  | history not yet holding N-1 vectors; accepts shift history, no output
//   RUN   | every accept shifts history and loads a new N-gram into the output
module temporal_encoder
    import temporal_encoder_pkg::*;
#(
    parameter int HV_DIMENSION = DEF_HV_DIMENSION,
    parameter int NGRAM_SIZE   = DEF_NGRAM_SIZE
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [HV_DIMENSION-1:0] HypervectorIn_DI,
    input  logic                    ClearHistory_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [HV_DIMENSION-1:0] HypervectorOut_DO
);

    localparam int               CNT_W       = ceil_log2(NGRAM_SIZE);
    localparam int               HIST_DEPTH  = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
    localparam state_e           RESET_STATE = (NGRAM_SIZE == 1) ? RUN : FILL;
    localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'((NGRAM_SIZE > 1) ? NGRAM_SIZE - 2 : 0);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [CNT_W-1:0]          r_fill_cnt;
    logic                      r_valid_out;
    logic [HV_DIMENSION-1:0]   r_hv_out;
    logic [HV_DIMENSION-1:0]   w_ngram;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_shift;
    logic                      w_load_out;
    logic                      w_fill_inc;

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) r_state <= RESET_STATE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ClearHistory_SI)
            w_state_nxt = RESET_STATE;
        else if ((r_state == FILL) && w_accept && (r_fill_cnt == FILL_LAST))
            w_state_nxt = RUN;
    end

    // Clear wins over accept; a held output blocks new input so nothing is lost.
    always_comb begin
        w_ready    = !ClearHistory_SI && (!r_valid_out || ReadyIn_SI);
        w_accept   = ValidIn_SI && w_ready;
        w_shift    = w_accept;
        w_load_out = w_accept && (r_state == RUN);
        w_fill_inc = w_accept && (r_state == FILL);
    end

    assign ReadyOut_SO = w_ready;

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI || ClearHistory_SI) r_fill_cnt <= '0;
        else if (w_fill_inc)             r_fill_cnt <= r_fill_cnt + CNT_W'(1);
    end

    generate
        if (NGRAM_SIZE > 1) begin : g_hist
            logic [HV_DIMENSION-1:0] r_hist      [HIST_DEPTH];
            logic [HV_DIMENSION-1:0] w_hist_perm [HIST_DEPTH];

            // History is stored already rotated, so stage k holds rho^k of an older input.
            for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_stage
                if (k == 0) begin : g_head
                    temporal_encoder_hv_permute #(.HV_DIMENSION(HV_DIMENSION)) u_perm (
                        .i_hv (HypervectorIn_DI),
                        .o_hv (w_hist_perm[k])
                    );
                end else begin : g_tail
                    temporal_encoder_hv_permute #(.HV_DIMENSION(HV_DIMENSION)) u_perm (
                        .i_hv (r_hist[k-1]),
                        .o_hv (w_hist_perm[k])
                    );
                end
            end

            always_ff @(posedge Clk_CI) begin
                if (Reset_RI || ClearHistory_SI) begin
                    for (int k = 0; k < HIST_DEPTH; k++) r_hist[k] <= '0;
                end else if (w_shift) begin
                    for (int k = 0; k < HIST_DEPTH; k++) r_hist[k] <= w_hist_perm[k];
                end
            end

            always_comb begin
                w_ngram = HypervectorIn_DI;
                for (int k = 0; k < HIST_DEPTH; k++) w_ngram = w_ngram ^ r_hist[k];
            end
        end else begin : g_no_hist
            assign w_ngram = HypervectorIn_DI;
        end
    endgenerate

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            r_valid_out <= 1'b0;
            r_hv_out    <= '0;
        end else if (w_load_out) begin
            r_valid_out <= 1'b1;
            r_hv_out    <= w_ngram;
        end else if (ReadyIn_SI) begin
            r_valid_out <= 1'b0;
        end
    end

    assign ValidOut_SO       = r_valid_out;
    assign HypervectorOut_DO = r_hv_out;

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed bench: D=8 with N=3 (vector table) and N=1 (hand sequence).
module tb_temporal_encoder;

    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         vin, clr, rdy, rdy_out, vld;
    logic [D-1:0] hv_in, hv_out;
    logic         n1_vin, n1_clr, n1_rdy, n1_rdy_out, n1_vld;
    logic [D-1:0] n1_hv_in, n1_hv_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    temporal_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(3)) dut (
        .Clk_CI            (clk),
        .Reset_RI          (rst),
        .ValidIn_SI        (vin),
        .ReadyOut_SO       (rdy_out),
        .HypervectorIn_DI  (hv_in),
        .ClearHistory_SI   (clr),
        .ValidOut_SO       (vld),
        .ReadyIn_SI        (rdy),
        .HypervectorOut_DO (hv_out)
    );

    temporal_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(1)) dut1 (
        .Clk_CI            (clk),
        .Reset_RI          (rst),
        .ValidIn_SI        (n1_vin),
        .ReadyOut_SO       (n1_rdy_out),
        .HypervectorIn_DI  (n1_hv_in),
        .ClearHistory_SI   (n1_clr),
        .ValidOut_SO       (n1_vld),
        .ReadyIn_SI        (n1_rdy),
        .HypervectorOut_DO (n1_hv_out)
    );

    typedef struct {
        logic         vin;
        logic         clr;
        logic         rdy;
        logic [D-1:0] hv;
        logic         exp_rdy_out;
        logic         exp_vld;
        logic         chk_out;
        logic [D-1:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic v, input logic c, input logic r, input logic [D-1:0] h,
                                 input logic er, input logic ev, input logic co, input logic [D-1:0] eo);
        vec_t t;
        t.vin = v; t.clr = c; t.rdy = r; t.hv = h;
        t.exp_rdy_out = er; t.exp_vld = ev; t.chk_out = co; t.exp_out = eo;
        return t;
    endfunction

    // One N=1 cycle: drive, check ReadyOut before the edge, check outputs after it.
    task automatic step1(input logic v, input logic c, input logic r, input logic [D-1:0] h,
                         input logic er, input logic ev, input logic [D-1:0] eo);
        n1_vin = v; n1_clr = c; n1_rdy = r; n1_hv_in = h;
        #1;
        check("n1_ready_out", D'(n1_rdy_out), D'(er));
        @(posedge clk); #1;
        check("n1_valid_out", D'(n1_vld), D'(ev));
        if (ev) check("n1_hv_out", n1_hv_out, eo);
    endtask

    initial begin
        rst = 1'b1;
        vin = 0; clr = 0; rdy = 0; hv_in = '0;
        n1_vin = 0; n1_clr = 0; n1_rdy = 0; n1_hv_in = '0;

        // rho() is rotate-left by one here: 80->01, 02->04, 66->CC.
        //                  vin  clr  rdy  hv     rdyO vld  chk  out
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h01, 1'b1,1'b0,1'b0,8'h00)); // A, fill
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h02, 1'b1,1'b0,1'b0,8'h00)); // B, fill
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h04, 1'b1,1'b1,1'b1,8'h04)); // C: 04^04^04
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h80, 1'b1,1'b1,1'b1,8'h80)); // 80^08^08
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h00, 1'b1,1'b1,1'b1,8'h11)); // 00^01^10 (wrap)
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h0F, 1'b1,1'b1,1'b1,8'h0D)); // 0F^00^02
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h33, 1'b1,1'b1,1'b1,8'h2D)); // 33^1E^00
        for (int i = 0; i < 5; i++)                                       // hold 5 cycles
            vecs.push_back(mkv(1'b1,1'b0,1'b0,8'hAA, 1'b0,1'b1,1'b1,8'h2D));
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'hAA, 1'b1,1'b1,1'b1,8'hF0)); // AA^66^3C
        vecs.push_back(mkv(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,8'hF0)); // pending
        vecs.push_back(mkv(1'b1,1'b1,1'b0,8'hFF, 1'b0,1'b1,1'b1,8'hF0)); // clear, still pending
        vecs.push_back(mkv(1'b0,1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0,8'h00)); // pending drains
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h01, 1'b1,1'b0,1'b0,8'h00)); // refill 1
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h10, 1'b1,1'b0,1'b0,8'h00)); // refill 2
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h40, 1'b1,1'b1,1'b1,8'h64)); // 40^20^04 post-clear
        vecs.push_back(mkv(1'b1,1'b1,1'b1,8'h12, 1'b0,1'b0,1'b0,8'h00)); // clear+valid: refused
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h01, 1'b1,1'b0,1'b0,8'h00)); // fill from count 0
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h02, 1'b1,1'b0,1'b0,8'h00));
        vecs.push_back(mkv(1'b1,1'b0,1'b1,8'h04, 1'b1,1'b1,1'b1,8'h04));
        vecs.push_back(mkv(1'b0,1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0,8'h00)); // drain, no accept
        vecs.push_back(mkv(1'b1,1'b0,1'b0,8'h08, 1'b1,1'b1,1'b1,8'h08)); // empty: ready w/o ReadyIn
        vecs.push_back(mkv(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,8'h08)); // held

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_valid_out", D'(vld), D'(1'b0));
        check("reset_hv_out", hv_out, 8'h00);
        check("reset_ready_out", D'(rdy_out), D'(1'b1));

        foreach (vecs[i]) begin
            vin = vecs[i].vin; clr = vecs[i].clr; rdy = vecs[i].rdy; hv_in = vecs[i].hv;
            #1;
            check($sformatf("v%0d_ready_out", i), D'(rdy_out), D'(vecs[i].exp_rdy_out));
            @(posedge clk); #1;
            check($sformatf("v%0d_valid_out", i), D'(vld), D'(vecs[i].exp_vld));
            if (vecs[i].chk_out)
                check($sformatf("v%0d_hv_out", i), hv_out, vecs[i].exp_out);
        end

        // Reset while an output is pending discards it.
        vin = 0; clr = 0; rdy = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_valid_out", D'(vld), D'(1'b0));
        check("midreset_hv_out", hv_out, 8'h00);
        rst = 1'b0;
        #1;
        check("midreset_ready_out", D'(rdy_out), D'(1'b1));

        // N=1: output equals input with one cycle of latency, no fill phase.
        step1(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A);
        step1(1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 8'h5A);
        step1(1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3);
        step1(1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
        step1(1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 8'h80);
        step1(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
